dk_rom_loader: RTL and testbench
================================

Name: dk_rom_loader

Overview:
- Sits between the HPS download port and the Donkey Kong core/ROM RAMs, upstream of dkong_top and the cpu/snd/wav dprams.
- Decodes the ioctl byte stream by index and address into registered write strobes for each ROM region and the core's DL port.
- Latches the game-variant byte and the DIP bytes.
- Runs a download-state FSM that holds the core in reset across a load and a settle window, and reports completion plus a byte count and checksum.

Parameters:
HOLD_CYCLES, 1024, clk_sys cycles core reset stays asserted after ioctl_download falls
ROM_INDEX, 0, ioctl_index carrying ROM data
MOD_INDEX, 1, ioctl_index carrying the variant byte
DIP_INDEX, 254, ioctl_index carrying DIP bytes

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle byte-valid strobe
ioctl_index  in  8  stream index
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
rom_addr  out  16  registered ioctl_addr[15:0]
rom_data  out  8  registered ioctl_dout
cpu_rom_wr  out  1  write to main CPU ROM
snd_rom_wr  out  1  write to sound CPU ROM
wav_rom_wr  out  1  write to sample ROM
dl_wr  out  1  write to core-internal ROMs (DL_WR)
mod_sel  out  5  one-hot {pestplace, radarscope, dk3, dkjr, dk}
dip_sw0  out  8  DIP byte 0
core_reset_hold  out  1  core reset request
load_done  out  1  load completed, core released
byte_count  out  17  ROM-index bytes accepted this load, saturating
checksum  out  16  mod-2^16 sum of ROM-index bytes this load

Behaviour:
- Reset values:
  - all strobes 0; rom_addr 0; rom_data 0
  - mod_sel 5'b00001; dip_sw0 8'h00
  - core_reset_hold 1; load_done 0; byte_count 0; checksum 0
  - FSM in IDLE
- Write pipeline: an accepted byte is ioctl_wr & ioctl_download. It appears on rom_addr/rom_data and its strobe(s) exactly 1 cycle later. Each strobe is high for exactly one cycle per accepted byte.
- Decode, applied only when index==ROM_INDEX:
  - cpu_rom_wr: addr < 0x08000
  - snd_rom_wr: 0x0E000 <= addr < 0x0F000
  - wav_rom_wr: 0x10000 <= addr < 0x20000
  - dl_wr: addr[23:16]==0, regardless of the cpu/snd ranges, so multiple strobes may be high together
  - addresses >= 0x20000 produce no strobe but still count and checksum
- Variant byte: index==MOD_INDEX with addr==0 sets mod_sel from the byte. Values 0..4 map to bits 0..4. Values >4 leave mod_sel unchanged. Writes at addr!=0 are ignored.
- DIP byte: index==DIP_INDEX with addr==0 updates dip_sw0. Addr 1..7 are accepted and discarded. Addr >= 8 is ignored.
- FSM:
  - IDLE → LOAD on an ioctl_download rise (edge taken from a 1-cycle registered copy).
  - LOAD → SETTLE on an ioctl_download fall. SETTLE loads the counter with HOLD_CYCLES-1.
  - SETTLE → DONE when the counter reaches 0.
  - DONE → LOAD on a new rise.
  - SETTLE → LOAD on a rise mid-settle; the counter is abandoned.
- Outputs per state:
  - core_reset_hold = 1 in IDLE, LOAD and SETTLE; 0 only in DONE.
  - load_done = 1 only in DONE.
- byte_count and checksum clear on entry to LOAD. They update in the cycle after each accepted ROM-index byte. byte_count saturates at 2^17-1; checksum wraps. Both hold their values in SETTLE and DONE.
- Non-ROM downloads (MOD/DIP index) also pass through LOAD/SETTLE and re-hold the core, matching existing top-level reset-on-download behaviour.
- ioctl_wr while ioctl_download=0 is ignored entirely.
- Reset mid-load returns to IDLE at the next edge, clears counters and drops strobes. mod_sel and dip_sw0 return to their reset values.

Decomposition:
- dk_loader_pkg:
  - region base/limit constants (CPU_END 0x08000, SND_BASE 0x0E000, SND_END 0x0F000, WAV_BASE 0x10000, WAV_END 0x20000)
  - FSM state enum {IDLE, LOAD, SETTLE, DONE}
  - MOD_* variant codes 0..4
- One sub-module, dk_loader_decode: combinational index/address to region-hit vector, so the decode can be unit-checked separately.

Test Plan:
- Index 0, bytes 0x11,0x22,0x33 at addr 0x0000..0x0002 → cpu_rom_wr and dl_wr pulse 1 cycle after each; rom_addr 0,1,2; after the download ends, byte_count=3, checksum=0x0066.
- Index 0, addr 0x0E005 data 0xA5, then addr 0x1FFFF data 0x5A → snd_rom_wr with rom_addr 0xE005; then wav_rom_wr with rom_addr 0xFFFF and dl_wr=0.
- Index 1, addr 0 data 0x03 → mod_sel=5'b01000. Then data 0x07 → mod_sel unchanged. Index 254, addr 0 data 0xC3 → dip_sw0=0xC3.
- HOLD_CYCLES=16: download falls at cycle T → core_reset_hold stays 1 through T+16 and load_done rises at T+17±1 (exact edge per registered-edge latency). A new download rise at T+8 → back to LOAD, load_done stays 0.
- 0x10000 bytes of 0xFF at index 0 → checksum=0x0000 (wraps), byte_count=0x10000. ioctl_wr pulses with ioctl_download=0 → no strobes, no count change.
- Reset asserted mid-LOAD → next cycle IDLE, strobes 0, byte_count 0, core_reset_hold 1, mod_sel 5'b00001.

Source files
------------

// File: rtl/dk_loader_pkg.sv
// Shared constants, FSM state and decode types for the Donkey Kong ROM loader.
package dk_loader_pkg;

  localparam logic [24:0] CPU_END  = 25'h000_8000;
  localparam logic [24:0] SND_BASE = 25'h000_E000;
  localparam logic [24:0] SND_END  = 25'h000_F000;
  localparam logic [24:0] WAV_BASE = 25'h001_0000;
  localparam logic [24:0] WAV_END  = 25'h002_0000;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

  localparam logic [7:0] MOD_DK         = 8'd0;
  localparam logic [7:0] MOD_DKJR       = 8'd1;
  localparam logic [7:0] MOD_DK3        = 8'd2;
  localparam logic [7:0] MOD_RADARSCOPE = 8'd3;
  localparam logic [7:0] MOD_PESTPLACE  = 8'd4;

  typedef struct packed {
    logic cpu;
    logic snd;
    logic wav;
    logic dl;
    logic rom;
    logic mod0;
    logic dip0;
  } hit_t;

endpackage

// File: rtl/dk_loader_decode.sv
// Combinational ioctl index/address decode into per-region hit flags.
import dk_loader_pkg::*;

module dk_loader_decode #(
  parameter int unsigned ROM_INDEX = 0,
  parameter int unsigned MOD_INDEX = 1,
  parameter int unsigned DIP_INDEX = 254
) (
  input  logic [7:0]  index,
  input  logic [24:0] addr,
  output hit_t        hit
);

  always_comb begin
    hit = '0;
    if (index == 8'(ROM_INDEX)) begin
      hit.rom = 1'b1;
      hit.cpu = addr < CPU_END;
      hit.snd = (addr >= SND_BASE) && (addr < SND_END);
      hit.wav = (addr >= WAV_BASE) && (addr < WAV_END);
      // DL covers the whole low 64K bank, overlapping the CPU and sound ranges.
      hit.dl  = addr[23:16] == 8'h00;
    end
    hit.mod0 = (index == 8'(MOD_INDEX)) && (addr == '0);
    hit.dip0 = (index == 8'(DIP_INDEX)) && (addr == '0);
  end

endmodule

// File: rtl/dk_rom_loader.sv
// ioctl download front end: ROM write strobes, variant/DIP latches, and core reset hold FSM.
import dk_loader_pkg::*;

module dk_rom_loader #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned ROM_INDEX   = 0,
  parameter int unsigned MOD_INDEX   = 1,
  parameter int unsigned DIP_INDEX   = 254
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_rom_wr,
  output logic        snd_rom_wr,
  output logic        wav_rom_wr,
  output logic        dl_wr,
  output logic [4:0]  mod_sel,
  output logic [7:0]  dip_sw0,
  output logic        core_reset_hold,
  output logic        load_done,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          dl_q;
  logic          accepted;
  logic          rise;
  logic          fall;
  logic          rom_byte;
  hit_t          hit;

  dk_loader_decode #(
    .ROM_INDEX (ROM_INDEX),
    .MOD_INDEX (MOD_INDEX),
    .DIP_INDEX (DIP_INDEX)
  ) u_decode (
    .index (ioctl_index),
    .addr  (ioctl_addr),
    .hit   (hit)
  );

  assign accepted = ioctl_wr & ioctl_download;
  assign rise     = ioctl_download & ~dl_q;
  assign fall     = ~ioctl_download & dl_q;
  assign rom_byte = accepted & hit.rom;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      dl_q            <= 1'b0;
      rom_addr        <= '0;
      rom_data        <= '0;
      cpu_rom_wr      <= 1'b0;
      snd_rom_wr      <= 1'b0;
      wav_rom_wr      <= 1'b0;
      dl_wr           <= 1'b0;
      mod_sel         <= 5'b00001;
      dip_sw0         <= '0;
      core_reset_hold <= 1'b1;
      load_done       <= 1'b0;
      byte_count      <= '0;
      checksum        <= '0;
    end else begin
      dl_q       <= ioctl_download;
      cpu_rom_wr <= accepted & hit.cpu;
      snd_rom_wr <= accepted & hit.snd;
      wav_rom_wr <= accepted & hit.wav;
      dl_wr      <= accepted & hit.dl;
      if (accepted) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
      if (accepted && hit.mod0 && (ioctl_dout <= MOD_PESTPLACE))
        mod_sel <= 5'(5'b00001 << ioctl_dout[2:0]);
      if (accepted && hit.dip0)
        dip_sw0 <= ioctl_dout;

      // A rise re-enters LOAD and clears the counters; a ROM byte on that same
      // edge is the first byte of the new load, so it seeds them instead.
      if (rise) begin
        byte_count <= rom_byte ? 17'd1 : 17'd0;
        checksum   <= rom_byte ? 16'(ioctl_dout) : 16'd0;
      end else if (rom_byte) begin
        if (byte_count != '1)
          byte_count <= byte_count + 17'd1;
        checksum <= checksum + 16'(ioctl_dout);
      end

      case (state)
        IDLE, DONE: begin
          if (rise) begin
            state           <= LOAD;
            core_reset_hold <= 1'b1;
            load_done       <= 1'b0;
          end
        end
        LOAD: begin
          if (fall) begin
            state      <= SETTLE;
            settle_cnt <= CW'(HOLD_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (rise) begin
            state <= LOAD;
          end else if (settle_cnt == '0) begin
            state           <= DONE;
            core_reset_hold <= 1'b0;
            load_done       <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dk_rom_loader.sv
// Randomised self-checking bench for dk_rom_loader against a spec-level model.
module tb_dk_rom_loader;

  localparam int unsigned HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_rom_wr, snd_rom_wr, wav_rom_wr, dl_wr;
  logic [4:0]  mod_sel;
  logic [7:0]  dip_sw0;
  logic        core_reset_hold, load_done;
  logic [16:0] byte_count;
  logic [15:0] checksum;
  logic [3:0]  strb;

  int checks = 0;
  int fails  = 0;

  assign strb = {cpu_rom_wr, snd_rom_wr, wav_rom_wr, dl_wr};

  dk_rom_loader #(
    .HOLD_CYCLES (HOLD),
    .ROM_INDEX   (0),
    .MOD_INDEX   (1),
    .DIP_INDEX   (254)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_download  (ioctl_download),
    .ioctl_wr        (ioctl_wr),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .cpu_rom_wr      (cpu_rom_wr),
    .snd_rom_wr      (snd_rom_wr),
    .wav_rom_wr      (wav_rom_wr),
    .dl_wr           (dl_wr),
    .mod_sel         (mod_sel),
    .dip_sw0         (dip_sw0),
    .core_reset_hold (core_reset_hold),
    .load_done       (load_done),
    .byte_count      (byte_count),
    .checksum        (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {cpu, snd, wav, dl} for one accepted byte, from the region table.
  function automatic logic [3:0] exp_hits(input int unsigned idx, input int unsigned a);
    logic c, s, w, d;
    if (idx != 0) return 4'b0000;
    c = a < 32'h8000;
    s = (a >= 32'hE000) && (a < 32'hF000);
    w = (a >= 32'h10000) && (a < 32'h20000);
    d = (a % 32'h100_0000) < 32'h10000;
    return {c, s, w, d};
  endfunction

  task automatic put(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk_sys); #1;
  endtask

  task automatic idle();
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b1; ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (strb !== 4'b0000) begin fails++; $display("FAIL reset_strobes: got %b expected 0000", strb); end
    checks++; if (rom_addr !== 16'h0 || rom_data !== 8'h0) begin fails++; $display("FAIL reset_rom: got %h/%h expected 0000/00", rom_addr, rom_data); end
    checks++; if (mod_sel !== 5'b00001) begin fails++; $display("FAIL reset_mod_sel: got %b expected 00001", mod_sel); end
    checks++; if (dip_sw0 !== 8'h00) begin fails++; $display("FAIL reset_dip: got %h expected 00", dip_sw0); end
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL reset_fsm_out: got hold=%b done=%b expected 1/0", core_reset_hold, load_done); end
    checks++; if (byte_count !== 17'd0 || checksum !== 16'd0) begin fails++; $display("FAIL reset_counts: got %h/%h expected 0/0", byte_count, checksum); end
    @(negedge clk_sys); reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL idle_hold: got hold=%b done=%b expected 1/0", core_reset_hold, load_done); end
  endtask

  task automatic test_cpu_dl();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    start_dl();
    for (int i = 0; i < 3; i++) begin
      put(8'd0, 25'(i), bytes[i]);
      checks++; if (strb !== 4'b1001) begin fails++; $display("FAIL cpu_strobe[%0d]: got %b expected 1001", i, strb); end
      checks++; if (rom_addr !== 16'(i) || rom_data !== bytes[i]) begin fails++; $display("FAIL cpu_rom[%0d]: got %h/%h expected %h/%h", i, rom_addr, rom_data, 16'(i), bytes[i]); end
    end
    idle();
    checks++; if (strb !== 4'b0000) begin fails++; $display("FAIL cpu_pulse_width: got %b expected 0000", strb); end
    end_dl();
    checks++; if (byte_count !== 17'd3 || checksum !== 16'h0066) begin fails++; $display("FAIL cpu_counts: got %h/%h expected 3/0066", byte_count, checksum); end
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL cpu_settle_hold: got hold=%b done=%b expected 1/0", core_reset_hold, load_done); end
  endtask

  task automatic test_regions();
    int unsigned bounds [12];
    bounds = '{32'h0E005, 32'h1FFFF, 32'h07FFF, 32'h08000, 32'h0DFFF, 32'h0E000,
               32'h0EFFF, 32'h0F000, 32'h0FFFF, 32'h10000, 32'h20000, 32'hFFFFFF};
    start_dl();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      put(8'd0, 25'(bounds[i]), d);
      checks++; if (strb !== exp_hits(0, bounds[i])) begin fails++; $display("FAIL region_strobe[%h]: got %b expected %b", bounds[i], strb, exp_hits(0, bounds[i])); end
      checks++; if (rom_addr !== 16'(bounds[i]) || rom_data !== d) begin fails++; $display("FAIL region_rom[%h]: got %h/%h expected %h/%h", bounds[i], rom_addr, rom_data, 16'(bounds[i]), d); end
    end
    end_dl();
    checks++; if (byte_count !== 17'd12) begin fails++; $display("FAIL region_count: got %0d expected 12", byte_count); end
  endtask

  task automatic test_random();
    int unsigned m_cnt;
    logic [15:0] m_sum;
    m_cnt = 0; m_sum = '0;
    start_dl();
    checks++; if (byte_count !== 17'd0 || checksum !== 16'd0) begin fails++; $display("FAIL rand_clear: got %h/%h expected 0/0", byte_count, checksum); end
    for (int n = 0; n < 300; n++) begin
      int unsigned a, idx;
      logic [7:0] d;
      if ($urandom_range(0, 4) == 0) begin
        idle();
        checks++; if (strb !== 4'b0000) begin fails++; $display("FAIL rand_gap[%0d]: got %b expected 0000", n, strb); end
      end
      idx = ($urandom_range(0, 7) == 0) ? 9 : 0;
      case ($urandom_range(0, 5))
        0: a = $urandom_range(32'h0, 32'h7FFF);
        1: a = $urandom_range(32'h8000, 32'hDFFF);
        2: a = $urandom_range(32'hE000, 32'hEFFF);
        3: a = $urandom_range(32'hF000, 32'hFFFF);
        4: a = $urandom_range(32'h10000, 32'h1FFFF);
        default: a = $urandom & 32'hFF_FFFF;
      endcase
      d = 8'($urandom);
      put(8'(idx), 25'(a), d);
      if (idx == 0) begin
        m_cnt = m_cnt + 1;
        m_sum = m_sum + 16'(d);
      end
      checks++; if (strb !== exp_hits(idx, a)) begin fails++; $display("FAIL rand_strobe[%0d]: idx=%0d addr=%h got %b expected %b", n, idx, a, strb, exp_hits(idx, a)); end
      checks++; if (rom_addr !== 16'(a) || rom_data !== d) begin fails++; $display("FAIL rand_rom[%0d]: got %h/%h expected %h/%h", n, rom_addr, rom_data, 16'(a), d); end
      checks++; if (byte_count !== 17'(m_cnt) || checksum !== m_sum) begin fails++; $display("FAIL rand_counts[%0d]: got %h/%h expected %h/%h", n, byte_count, checksum, 17'(m_cnt), m_sum); end
    end
    end_dl();
    checks++; if (byte_count !== 17'(m_cnt) || checksum !== m_sum) begin fails++; $display("FAIL rand_final: got %h/%h expected %h/%h", byte_count, checksum, 17'(m_cnt), m_sum); end
  endtask

  task automatic test_variant();
    logic [4:0] m_mod;
    logic [7:0] m_dip;
    m_mod = mod_sel; m_dip = dip_sw0;
    start_dl();
    put(8'd1, 25'd0, 8'h03);
    m_mod = 5'b01000;
    checks++; if (mod_sel !== m_mod) begin fails++; $display("FAIL mod_set3: got %b expected %b", mod_sel, m_mod); end
    checks++; if (strb !== 4'b0000) begin fails++; $display("FAIL mod_no_strobe: got %b expected 0000", strb); end
    put(8'd1, 25'd0, 8'h07);
    checks++; if (mod_sel !== m_mod) begin fails++; $display("FAIL mod_ignore7: got %b expected %b", mod_sel, m_mod); end
    for (int n = 0; n < 12; n++) begin
      int unsigned v, a;
      v = $urandom_range(0, 9);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      put(8'd1, 25'(a), 8'(v));
      if (a == 0 && v <= 4) m_mod = 5'd0 | (5'd1 << v);
      checks++; if (mod_sel !== m_mod) begin fails++; $display("FAIL mod_rand[%0d]: v=%0d a=%0d got %b expected %b", n, v, a, mod_sel, m_mod); end
    end
    put(8'd254, 25'd0, 8'hC3);
    m_dip = 8'hC3;
    checks++; if (dip_sw0 !== m_dip) begin fails++; $display("FAIL dip_set: got %h expected %h", dip_sw0, m_dip); end
    put(8'd254, 25'd3, 8'h55);
    put(8'd254, 25'd8, 8'hAA);
    checks++; if (dip_sw0 !== m_dip) begin fails++; $display("FAIL dip_ignore: got %h expected %h", dip_sw0, m_dip); end
    checks++; if (byte_count !== 17'd0 || checksum !== 16'd0) begin fails++; $display("FAIL variant_no_count: got %h/%h expected 0/0", byte_count, checksum); end
    put(8'd1, 25'd0, 8'h03);
    m_mod = 5'b01000;
    end_dl();
  endtask

  task automatic test_settle();
    start_dl();
    put(8'd0, 25'h100, 8'h42);
    end_dl();
    // Edge 1 after the drop enters SETTLE; release arrives HOLD edges later.
    for (int k = 1; k <= int'(HOLD) + 1; k++) begin
      if (k > 1) begin @(posedge clk_sys); #1; end
      checks++; if (load_done !== (k == int'(HOLD) + 1) || core_reset_hold !== (k != int'(HOLD) + 1)) begin
        fails++; $display("FAIL settle_edge[%0d]: got hold=%b done=%b", k, core_reset_hold, load_done);
      end
    end
    checks++; if (byte_count !== 17'd1 || checksum !== 16'h0042) begin fails++; $display("FAIL done_counts_held: got %h/%h expected 1/0042", byte_count, checksum); end
    start_dl();
    checks++; if (load_done !== 1'b0 || core_reset_hold !== 1'b1 || byte_count !== 17'd0) begin fails++; $display("FAIL done_to_load: got hold=%b done=%b cnt=%h", core_reset_hold, load_done, byte_count); end
    end_dl();
    repeat (7) begin @(posedge clk_sys); #1; end
    start_dl();
    for (int k = 0; k < int'(HOLD) + 4; k++) begin
      checks++; if (load_done !== 1'b0 || core_reset_hold !== 1'b1) begin fails++; $display("FAIL settle_abort[%0d]: got hold=%b done=%b expected 1/0", k, core_reset_hold, load_done); end
      @(posedge clk_sys); #1;
    end
    end_dl();
    repeat (HOLD) begin @(posedge clk_sys); #1; end
    checks++; if (load_done !== 1'b1 || core_reset_hold !== 1'b0) begin fails++; $display("FAIL settle_restart_done: got hold=%b done=%b expected 0/1", core_reset_hold, load_done); end
  endtask

  task automatic test_wrap();
    start_dl();
    for (int i = 0; i < 32'h10000; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 25'(i); ioctl_dout = 8'hFF;
      @(posedge clk_sys);
    end
    idle();
    checks++; if (byte_count !== 17'h10000 || checksum !== 16'h0000) begin fails++; $display("FAIL wrap_counts: got %h/%h expected 10000/0000", byte_count, checksum); end
    end_dl();
    for (int n = 0; n < 6; n++) begin
      put(8'd0, 25'($urandom_range(0, 32'h1FFFF)), 8'($urandom));
      checks++; if (strb !== 4'b0000 || byte_count !== 17'h10000 || checksum !== 16'h0000) begin
        fails++; $display("FAIL wr_no_download[%0d]: got strb=%b cnt=%h sum=%h expected 0000/10000/0000", n, strb, byte_count, checksum);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    start_dl();
    put(8'd0, 25'h10, 8'h5A);
    put(8'd0, 25'h11, 8'hA5);
    @(negedge clk_sys);
    reset = 1'b1; ioctl_wr = 1'b1; ioctl_index = 8'd0; ioctl_addr = 25'h12; ioctl_dout = 8'h77;
    @(posedge clk_sys); #1;
    checks++; if (strb !== 4'b0000 || rom_addr !== 16'h0) begin fails++; $display("FAIL rst_mid_strobes: got %b/%h expected 0000/0000", strb, rom_addr); end
    checks++; if (byte_count !== 17'd0 || checksum !== 16'd0) begin fails++; $display("FAIL rst_mid_counts: got %h/%h expected 0/0", byte_count, checksum); end
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL rst_mid_fsm: got hold=%b done=%b expected 1/0", core_reset_hold, load_done); end
    checks++; if (mod_sel !== 5'b00001 || dip_sw0 !== 8'h00) begin fails++; $display("FAIL rst_mid_latches: got %b/%h expected 00001/00", mod_sel, dip_sw0); end
    @(negedge clk_sys);
    reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    repeat (HOLD + 4) @(posedge clk_sys);
    #1;
    checks++; if (core_reset_hold !== 1'b1 || load_done !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got hold=%b done=%b expected 1/0", core_reset_hold, load_done); end
  endtask

  initial begin
    test_reset();
    test_cpu_dl();
    test_regions();
    test_random();
    test_variant();
    test_settle();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
